// File: rtl/mul16_seq_if.sv
// Start/busy/done handshake bundle between a datapath master and the iterative multiplier.
interface mul16_seq_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;

  modport master (output start, a, b, input busy, done, out);
  modport slave  (input start, a, b, output busy, done, out);
endinterface

// File: rtl/mul16_seq.sv
// Unsigned shift-and-add multiplier, one AND-masked partial product per clock.
// Result and done pulse WIDTH+1 edges after accept; start is ignored while busy.
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  mul16_seq_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_out;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0] w_sum;

  assign w_pp  = r_a & {WIDTH{r_b[0]}};
  assign w_sum = r_acc + ({{WIDTH{1'b0}}, w_pp} << r_cnt);
  assign w_last = (r_cnt == CNT_W'(WIDTH-1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        // Back-to-back accept skips IDLE entirely.
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_sum;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_out <= w_sum;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.out  = r_out;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed-vector bench for mul16_seq: latency, handshake, reset abort and back-to-back.
module tb_mul16_seq;

  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mul16_seq_if #(.WIDTH(WIDTH)) bus ();

  mul16_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Accepts one operation, optionally pokes start=1 (a=1,b=1) at RUN cycle `poke`.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] expv, input int poke);
    int lat;
    int nbusy;
    bit seen;
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    step();
    bus.start = 1'b0;
    lat = 1; nbusy = 0; seen = 1'b0;
    while (lat < 40 && !seen) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        if (lat == poke) begin
          bus.start = 1'b1; bus.a = 16'd1; bus.b = 16'd1;
        end else begin
          bus.start = 1'b0;
        end
        step();
        lat++;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'd17);
    chk({tag, "_busycyc"}, 32'(nbusy), 32'd16);
    chk({tag, "_out"}, bus.out, expv);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_out_hold"}, bus.out, expv);
  endtask

  initial begin
    int lat;
    int ndone;
    n_chk = 0; n_fail = 0;

    // Reset held with start asserted: nothing may begin.
    reset = 1'b1; bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd9;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_out", bus.out, 32'd0);
    end
    reset = 1'b0; bus.start = 1'b0;
    step();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    do_op("mul3x5", 16'd3, 16'd5, 32'd15, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold15_out", bus.out, 32'd15);
      chk("hold15_done", 32'(bus.done), 32'd0);
    end

    do_op("full", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    do_op("msb", 16'h8000, 16'h0002, 32'h00010000, 0);
    do_op("ignore", 16'd100, 16'd200, 32'd20000, 5);

    // Abort on the 8th RUN edge.
    bus.start = 1'b1; bus.a = 16'd1234; bus.b = 16'd5678;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_out", bus.out, 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    do_op("mul12x12", 16'd12, 16'd12, 32'd144, 0);

    // Back-to-back: start held high through the done cycle.
    bus.start = 1'b1; bus.a = 16'd6; bus.b = 16'd7;
    step();
    bus.a = 16'd0; bus.b = 16'd1234;
    lat = 1;
    while (lat < 40 && !bus.done) begin
      step();
      lat++;
    end
    chk("b2b_lat1", 32'(lat), 32'd17);
    chk("b2b_out1", bus.out, 32'd42);
    step();
    bus.start = 1'b0;
    chk("b2b_busy_next", 32'(bus.busy), 32'd1);
    chk("b2b_done_next", 32'(bus.done), 32'd0);
    chk("b2b_out_held", bus.out, 32'd42);
    lat = 1;
    while (lat < 40 && !bus.done) begin
      step();
      lat++;
    end
    chk("b2b_lat2", 32'(lat), 32'd17);
    chk("b2b_out2", bus.out, 32'd0);
    step();
    chk("b2b_done_pulse", 32'(bus.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Iterative unsigned shift-and-add multiplier built on the bitwise-AND gate layer, consuming one AND-masked partial product per clock.
- Each cycle the partial product is the multiplicand ANDed with the current multiplier bit replicated across WIDTH bits.
- Sits above the gate library as the first multi-cycle arithmetic stage.
- Uses a start/busy/done handshake toward the datapath.

Parameters:
- WIDTH, 16, operand width in bits. The product is 2*WIDTH bits. Only 16 is required to be verified.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only when busy=0
- a  input  WIDTH  multiplicand, captured on the accepting edge
- b  input  WIDTH  multiplier, captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: out is valid and newly updated
- out  output  2*WIDTH  unsigned product; held until the next done

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, out=0, internal accumulator, operand registers and counter all 0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accept: on an edge where start=1 and state is IDLE or DONE:
  - capture a into a_reg and b into b_reg;
  - clear acc and cnt to 0;
  - go to RUN.
  - start is ignored while in RUN; a and b are don't-care outside the accepting edge.
- RUN step, one per edge:
  - pp = a_reg AND {WIDTH{b_reg[0]}};
  - acc <= acc + (pp << cnt), full 2*WIDTH-bit add, no overflow possible;
  - b_reg <= b_reg >> 1;
  - cnt <= cnt + 1.
  - The counter is wide enough to hold WIDTH-1 without wrap.
- Exit RUN: on the edge that performs the step with cnt == WIDTH-1:
  - out <= final sum;
  - go to DONE, so busy falls and done rises on the same edge.
- Timing:
  - Fixed latency: accept edge T0, RUN steps on edges T0+1 .. T0+WIDTH.
  - done=1 and out valid in the cycle after edge T0+WIDTH, i.e. WIDTH+1 edges after accept.
  - No early termination, even for b=0 or a=0.
- DONE → RUN: if start=1 in the DONE cycle, it is accepted (back-to-back operation) and the state goes straight to RUN. Otherwise DONE → IDLE.
- out is stable in all states except on the DONE-entry edge and on reset.
- Reset mid-operation: the operation is aborted and no done is produced. All outputs return to reset values on that edge.
- reset has priority over start on the same edge.
- Arithmetic is unsigned only; the result equals a*b exactly for all operand values.

Test Plan:
- Reset: assert reset for 2 edges with start=1, a=7, b=9 → busy=0, done=0, out=0; no operation starts.
- Basic multiply: start one cycle with a=3, b=5 → busy=1 for 16 cycles, then done=1 for exactly one cycle, out=32'd15. busy=0 after that; out holds 15 for 10 further idle cycles.
- Full-scale: a=16'hFFFF, b=16'hFFFF → out=32'hFFFE0001. Also a=16'h8000, b=16'h0002 → out=32'h00010000.
- Start while busy ignored: accept a=100, b=200; pulse start with a=1, b=1 at cycle 5 of RUN → single done, out=32'd20000, latency unchanged at 17 edges.
- Reset mid-run: accept a=1234, b=5678; assert reset on the 8th RUN edge → busy=0, out=0, no done pulse. A following a=12, b=12 → out=144.
- Back-to-back: accept a=6, b=7; hold start=1 with a=0, b=1234 through the done cycle → first done with out=42, busy=1 in the very next cycle, second done 17 edges later with out=0.
